// File: rtl/orion_pkg.sv
// Shared definitions for the sequence generator: FSM encoding, store geometry
// and the LFSR step used to produce candidate digits.
package orion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         SEQ_DEPTH = 32;
    localparam int         ADDR_W    = $clog2(SEQ_DEPTH);
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // x^8+x^6+x^5+x^4+1 as Fibonacci taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/digit_ram.sv
// 32x4 digit store: one synchronous write port, one registered read port.
// The array itself is never reset; only the read register is.
module digit_ram
    import orion_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [3:0]        i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [3:0]        o_rd_data
);

    logic [3:0] r_mem [SEQ_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Same-cycle read of the address being written returns the old contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rd_data <= 4'd0;
        end else begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/sequence_generator.sv
// Fills the digit store with LFSR-derived decimal digits on a start pulse.
//   state   | meaning
//   IDLE    | waiting for GoGen; SeqLen latched on acceptance
//   GEN     | writing accepted digits (0-9) at consecutive addresses
//   DONE    | one-cycle FinGen pulse, then back to IDLE
module sequence_generator
    import orion_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        GoGen,
    input  logic [1:0]  Diff,
    input  logic [4:0]  SeqAddr,
    output logic [3:0]  RAMOutput,
    output logic        FinGen,
    output logic        Busy,
    output logic [5:0]  SeqLen
);

    state_t            r_state;
    logic [7:0]        r_lfsr;
    logic [ADDR_W-1:0] r_wr_addr;

    logic [3:0]        w_cand;
    logic              w_accept;
    logic              w_wr_en;
    logic              w_last;
    logic [2:0]        w_diff_p1;
    logic [5:0]        w_len;

    assign w_cand    = r_lfsr[3:0];
    assign w_accept  = (w_cand <= DIGIT_MAX);
    assign w_wr_en   = (r_state == ST_GEN) && w_accept;
    assign w_last    = ({1'b0, r_wr_addr} == (SeqLen - 6'd1));
    assign w_diff_p1 = {1'b0, Diff} + 3'd1;
    assign w_len     = {w_diff_p1, 3'b000};

    // The LFSR free-runs in every state so the sequence depends on start timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_wr_addr <= '0;
            SeqLen    <= 6'd8;
            FinGen    <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            FinGen <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (GoGen) begin
                        SeqLen    <= w_len;
                        r_wr_addr <= '0;
                        Busy      <= 1'b1;
                        r_state   <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    if (w_accept) begin
                        r_wr_addr <= r_wr_addr + 5'd1;
                        if (w_last) begin
                            Busy    <= 1'b0;
                            FinGen  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    digit_ram u_digit_ram (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (w_cand),
        .i_rd_addr (SeqAddr),
        .o_rd_data (RAMOutput)
    );

endmodule
